// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU; one operation in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for alternating grants on ties; default is fixed priority (req0).
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [3:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [3:0]       req1_sel,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [WIDTH-1:0] alu_op2_q, alu_op2_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             req_id_q, req_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic             last_grant_q, last_grant_d;
`endif

  logic gnt_any;
  logic gnt_id;
  logic accept;
  logic sel_illegal;

  always_comb begin
    gnt_any = req0_valid | req1_valid;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not win last time is served.
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = ~req0_valid;
    end
`else
    gnt_id = ~req0_valid;
`endif
  end

  assign accept      = (state_q == StIdle) && gnt_any;
  assign req0_ready  = rst && accept && !gnt_id;
  assign req1_ready  = rst && accept && gnt_id;
  assign sel_illegal = (alu_sel_q > 4'd10);

  always_comb begin
    state_d     = state_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_sel_d   = alu_sel_q;
    req_id_d    = req_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          alu_op1_d = gnt_id ? req1_op1 : req0_op1;
          alu_op2_d = gnt_id ? req1_op2 : req0_op2;
          alu_sel_d = gnt_id ? req1_sel : req0_sel;
          req_id_d  = gnt_id;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          last_grant_d = gnt_id;
`endif
          state_d   = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = sel_illegal ? '0 : alu_out;
        rsp_err_d   = sel_illegal;
        rsp_id_d    = req_id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_sel_q   <= '0;
      req_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_sel_q   <= alu_sel_d;
      req_id_q    <= req_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural shared ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_sel, req1_sel, alu_sel;
  logic [31:0] alu_op1, alu_op2, alu_out, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op1  (req0_op1),
    .req0_op2  (req0_op2),
    .req0_sel  (req0_sel),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op1  (req1_op1),
    .req1_op2  (req1_op2),
    .req1_sel  (req1_sel),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  // Shared ALU; illegal selects return a junk pattern the arbiter must mask.
  always_comb begin
    alu_out = 32'hDEADBEEF;
    case (alu_sel)
      4'd0:  alu_out = alu_op1 + alu_op2;
      4'd1:  alu_out = alu_op1 - alu_op2;
      4'd2:  alu_out = alu_op1 & alu_op2;
      4'd3:  alu_out = alu_op1 | alu_op2;
      4'd4:  alu_out = alu_op1 ^ alu_op2;
      4'd5:  alu_out = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
      4'd6:  alu_out = {31'd0, alu_op1 < alu_op2};
      4'd7:  alu_out = alu_op1 << alu_op2[4:0];
      4'd8:  alu_out = alu_op1 >> alu_op2[4:0];
      4'd9:  alu_out = $signed(alu_op1) >>> alu_op2[4:0];
      4'd10: alu_out = alu_op1;
      default: alu_out = 32'hDEADBEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op from a lone requester; it must be accepted in the same cycle.
  task automatic issue(input bit which, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b);
    if (which) begin
      req1_valid = 1'b1; req1_sel = sel; req1_op1 = a; req1_op2 = b;
    end else begin
      req0_valid = 1'b1; req0_sel = sel; req0_op1 = a; req0_op2 = b;
    end
    #1;
    chk("issue_ready0", {31'd0, req0_ready}, {31'd0, !which});
    chk("issue_ready1", {31'd0, req1_ready}, {31'd0, which});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input bit id, input logic [31:0] data,
                         input bit err);
    for (int i = 0; i < 6 && !rsp_valid; i++) tick();
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    chk({tag, "_data"}, rsp_data, data);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, err});
    tick();
  endtask

  initial begin
    bit exp_id;
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_op1 = 32'd0; req0_op2 = 32'd0; req0_sel = 4'd0;
    req1_op1 = 32'd0; req1_op2 = 32'd0; req1_sel = 4'd0;
    tick();
    tick();
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Idle with nothing offered
    chk("noop_ready0", {31'd0, req0_ready}, 32'd0);
    chk("noop_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("noop_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // ADD 5+7 with exact two-cycle latency
    issue(1'b0, 4'd0, 32'd5, 32'd7);
    chk("add_c1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_c1_alu_op1", alu_op1, 32'd5);
    tick();
    chk("add_c2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_c2_data", rsp_data, 32'd12);
    chk("add_c2_id", {31'd0, rsp_id}, 32'd0);
    chk("add_c2_err", {31'd0, rsp_err}, 32'd0);
    tick();
    chk("add_c3_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("idle_hold_alu_op2", alu_op2, 32'd7);

    // Illegal select, then a normal SUB
    issue(1'b0, 4'd13, 32'd9, 32'd9);
    get_rsp("illegal", 1'b0, 32'd0, 1'b1);
    issue(1'b0, 4'd1, 32'd3, 32'd5);
    get_rsp("sub", 1'b0, 32'hFFFFFFFE, 1'b0);

    // SLTU / SLT on the same operands
    issue(1'b0, 4'd6, 32'd1, 32'hFFFFFFFF);
    get_rsp("sltu", 1'b0, 32'd1, 1'b0);
    issue(1'b0, 4'd5, 32'd1, 32'hFFFFFFFF);
    get_rsp("slt", 1'b0, 32'd0, 1'b0);

    // SRA with response back-pressure; both requesters waiting meanwhile
    rsp_ready = 1'b0;
    issue(1'b1, 4'd9, 32'h80000000, 32'd4);
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sra_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("sra_hold_data", rsp_data, 32'hF8000000);
      chk("sra_hold_id", {31'd0, rsp_id}, 32'd1);
      chk("sra_hold_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    #1;
    chk("sra_last_valid", {31'd0, rsp_valid}, 32'd1);
    tick();
    chk("sra_done_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset while EXEC: the operation is dropped
    issue(1'b1, 4'd10, 32'h12345678, 32'd0);
    rst = 1'b0;
    tick();
    chk("exec_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_rst_rsp_data", rsp_data, 32'd0);
    chk("exec_rst_alu_op1", alu_op1, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("exec_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end

    // Both requesters valid every cycle for four operations
    req0_valid = 1'b1; req0_sel = 4'd0; req0_op1 = 32'd10; req0_op2 = 32'd1;
    req1_valid = 1'b1; req1_sel = 4'd0; req1_op1 = 32'd20; req1_op2 = 32'd2;
    #1;
    chk("tie_first_ready0", {31'd0, req0_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_id = (k % 2) == 1;
`else
      exp_id = 1'b0;
`endif
      for (int i = 0; i < 8 && !rsp_valid; i++) begin
        chk("tie_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        tick();
      end
      chk("tie_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("tie_rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
      chk("tie_rsp_data", rsp_data, exp_id ? 32'd22 : 32'd11);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    chk("end_idle_valid", {31'd0, rsp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
